// File: rtl/if_id_decode_buffer_if.sv
// rtl/if_id_decode_buffer_if.sv - fetch/decode handshake bundle for the IF/ID buffer
interface if_id_decode_buffer_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [3:0]         out_opcode;
    logic [5:0]         out_rd;
    logic [5:0]         out_rs;
    logic [5:0]         out_rt;
    logic [1:0]         occupancy;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc,
        input  out_opcode, out_rd, out_rs, out_rt, occupancy
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc,
        output out_opcode, out_rd, out_rs, out_rt, occupancy
    );
endinterface

// File: rtl/if_id_decode_buffer.sv
// rtl/if_id_decode_buffer.sv - 2-entry IF/ID skid buffer with field split, stall and flush
module if_id_decode_buffer #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    if_id_decode_buffer_if.slave       bus
);
    logic [INSTR_W-1:0] mem_instr [2];
    logic [PC_W-1:0]    mem_pc    [2];
    logic               head;
    logic               tail;
    logic [1:0]         count;
    logic               push;
    logic               pop;

    assign bus.in_ready  = ~rst & (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Storage is never cleared; emptiness is handled by masking the outputs.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_instr[tail] <= bus.in_instr;
            mem_pc[tail]    <= bus.in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign bus.out_instr  = bus.out_valid ? mem_instr[head] : NOP_INSTR;
    assign bus.out_pc     = bus.out_valid ? mem_pc[head] : '0;
    assign bus.out_opcode = bus.out_instr[31:28];
    assign bus.out_rd     = bus.out_instr[27:22];
    assign bus.out_rs     = bus.out_instr[21:16];
    assign bus.out_rt     = bus.out_instr[15:10];
    assign bus.occupancy  = count;
endmodule

// File: tb/tb_if_id_decode_buffer.sv
// tb/tb_if_id_decode_buffer.sv - randomized bench against a queue reference model
module tb_if_id_decode_buffer;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    if_id_decode_buffer_if #(.INSTR_W(32), .PC_W(32)) bus ();

    if_id_decode_buffer #(.INSTR_W(32), .PC_W(32), .NOP_INSTR(32'h0)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ei;
        logic [31:0] ep;
        ei = (q.size() > 0) ? q[0].instr : 32'h0;
        ep = (q.size() > 0) ? q[0].pc : 32'h0;
        check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        check("occupancy", 64'(bus.occupancy), 64'(q.size()));
        check("out_instr", 64'(bus.out_instr), 64'(ei));
        check("out_pc", 64'(bus.out_pc), 64'(ep));
        check("opcode", 64'(bus.out_opcode), 64'(ei / 32'h1000_0000));
        check("rd", 64'(bus.out_rd), 64'((ei / 32'h40_0000) % 64));
        check("rs", 64'(bus.out_rs), 64'((ei / 32'h1_0000) % 64));
        check("rt", 64'(bus.out_rt), 64'((ei / 32'h400) % 64));
    endtask

    // One clock: apply inputs at negedge, advance model at posedge, compare at next negedge.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, output logic accepted);
        logic exp_ready;
        logic do_pop;
        entry_t e;
        rst           = r;
        flush         = f;
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        #1;
        exp_ready = !r && (q.size() < 2);
        check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        accepted = iv && exp_ready;
        do_pop   = ordy && (q.size() > 0);
        @(posedge clk);
        if (r || f) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (accepted) begin
                e.instr = ins;
                e.pc    = pc;
                q.push_back(e);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic acc;
        logic [31:0] hi;
        logic [31:0] hp;
        logic hv;
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_pc = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // reset, then the documented field-split example
        cycle(1, 0, 0, 0, 0, 0, acc);
        cycle(1, 0, 0, 0, 0, 0, acc);
        cycle(0, 0, 1, 32'h1C41_0800, 32'h10, 0, acc);
        check("ex_opcode", 64'(bus.out_opcode), 64'h1);
        check("ex_rd", 64'(bus.out_rd), 64'd49);
        check("ex_rs", 64'(bus.out_rs), 64'd1);
        check("ex_rt", 64'(bus.out_rt), 64'd2);
        cycle(1, 0, 0, 0, 0, 0, acc);

        // stall fill: A, B taken, C held until space frees
        cycle(0, 0, 1, 32'hAAAA_0001, 32'h100, 0, acc);
        cycle(0, 0, 1, 32'hBBBB_0002, 32'h104, 0, acc);
        cycle(0, 0, 1, 32'hCCCC_0003, 32'h108, 0, acc);
        check("c_held", 64'(acc), 64'd0);
        cycle(0, 0, 1, 32'hCCCC_0003, 32'h108, 1, acc);
        cycle(0, 0, 0, 0, 0, 1, acc);
        cycle(0, 0, 0, 0, 0, 1, acc);
        cycle(0, 0, 0, 0, 0, 1, acc);

        // steady push+pop at occupancy 1
        cycle(0, 0, 1, 32'h5000_0000, 32'h200, 0, acc);
        for (int i = 1; i <= 8; i++)
            cycle(0, 0, 1, 32'h5000_0000 + i, 32'h200 + 4 * i, 1, acc);

        // flush while full with a push offered, then resume
        cycle(0, 0, 1, 32'h6000_0001, 32'h300, 0, acc);
        cycle(0, 1, 1, 32'h6000_0002, 32'h304, 1, acc);
        cycle(0, 0, 1, 32'h6000_0003, 32'h308, 0, acc);
        cycle(0, 0, 1, 32'h6000_0004, 32'h30C, 0, acc);

        // reset mid-stream while full and draining
        cycle(1, 0, 1, 32'h7000_0001, 32'h400, 1, acc);
        cycle(0, 0, 0, 0, 0, 1, acc);
        cycle(0, 0, 0, 0, 0, 1, acc);

        // randomized traffic; fetch holds an unaccepted word
        hv = 1'b0;
        hi = '0;
        hp = '0;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic f;
            logic o;
            if (!hv) begin
                hv = ($urandom_range(0, 3) != 0);
                hi = $urandom;
                hp = $urandom;
            end
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 5);
            o = ($urandom_range(0, 2) != 0);
            cycle(r, f, hv, hi, hp, o, acc);
            if (acc || r || f) hv = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
